// File: rtl/io_cond_pkg.sv
// Shared defaults and helpers for the board-input conditioning front end.
package io_cond_pkg;

  localparam int unsigned IO_NUM_SW        = 17;
  localparam int unsigned IO_NUM_KEY       = 4;
  localparam int unsigned IO_NUM_CH        = IO_NUM_SW + IO_NUM_KEY;
  localparam int unsigned IO_DEBOUNCE_10MS = 500000;
  localparam logic [IO_NUM_CH-1:0] IO_KEY_ACTIVE_LOW_MASK = 21'h1E0000;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, accepted level and edge pulses.
module io_debounce_ch
  import io_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_10MS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  input  logic i_bypass,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic [31:0]            d_minus_1;
  logic                   s;
  logic                   mismatch;

  assign s = sync_q[SYNC_STAGES-1];

  // ">=" rather than "==" so a bypass switch mid-count accepts immediately.
  always_comb begin
    d_minus_1 = i_bypass ? '0 : 32'(DEBOUNCE_CYCLES - 1);
    mismatch  = s ^ o_level;
    o_accept  = mismatch && (32'(cnt) >= d_minus_1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
      o_rise <= o_accept & s;
      o_fall <= o_accept & ~s;
      if (!mismatch) begin
        cnt <= '0;
      end else if (o_accept) begin
        o_level <= s;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Board-input front end: polarity fix, per-channel sync/debounce, aggregated event pulse.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned          NUM_CH          = IO_NUM_CH,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = IO_DEBOUNCE_10MS,
  parameter logic [NUM_CH-1:0]    ACTIVE_LOW_MASK = NUM_CH'(IO_KEY_ACTIVE_LOW_MASK)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_raw,
  input  logic              i_bypass,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic              o_any_event
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_input_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("io_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("io_input_conditioner: NUM_CH must be >= 1");
  end

  logic [NUM_CH-1:0] in_hi;
  logic [NUM_CH-1:0] accept;

  assign in_hi = i_raw ^ ACTIVE_LOW_MASK;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_in    (in_hi[i]),
      .i_bypass(i_bypass),
      .o_level (o_level[i]),
      .o_rise  (o_rise[i]),
      .o_fall  (o_fall[i]),
      .o_accept(accept[i])
    );
  end

  // Registered from the channels' accept strobes so it lines up with the pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_any_event <= 1'b0;
    else       o_any_event <= |accept;
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Cycle-accurate vector bench for io_input_conditioner (4 channels, D=4, 2 sync stages).
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic       bypass;
  logic [3:0] level, rise, fall;
  logic       any_event;

  io_input_conditioner #(
    .NUM_CH         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_MASK(4'b1100)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_raw      (raw),
    .i_bypass   (bypass),
    .o_level    (level),
    .o_rise     (rise),
    .o_fall     (fall),
    .o_any_event(any_event)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic       byp;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  typedef struct {
    int         step;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // n cycles with these inputs, each followed by these outputs after the edge
  function automatic void add(input int n, input logic r, input logic b, input logic [3:0] rw,
                              input logic [3:0] l, input logic [3:0] ri, input logic [3:0] fa,
                              input logic an);
    vec_t v;
    v.n = n; v.rst = r; v.byp = b; v.raw = rw;
    v.lvl = l; v.rise = ri; v.fall = fa; v.any = an;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int step, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %b want %b", nm, step, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   step;
    exp_t e;
    exp_t got_e;
    rst    = 1'b1;
    raw    = 4'b1100;
    bypass = 1'b0;

    // reset with keys released, then idle
    add(10, 1, 0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0);
    add(10, 0, 0, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0);
    // ch0 rises: level after 6 edges, one rise pulse
    add(5,  0, 0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b1101, 4'b0001, 4'b0001, 4'b0000, 1);
    add(3,  0, 0, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 0);
    // ch1 glitch lasting D-1 synced cycles is rejected
    add(3,  0, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 0);
    add(6,  0, 0, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 0);
    // ch2 active-low key press, then release
    add(5,  0, 0, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b1001, 4'b0101, 4'b0100, 4'b0000, 1);
    add(3,  0, 0, 4'b1001, 4'b0101, 4'b0000, 4'b0000, 0);
    add(5,  0, 0, 4'b1101, 4'b0101, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b1101, 4'b0001, 4'b0000, 4'b0100, 1);
    add(3,  0, 0, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 0);
    // simultaneous ch0 fall and ch3 press
    add(5,  0, 0, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 1);
    add(3,  0, 0, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 0);

    // Hand-written corner sequences.
    // bypass: ch1 rise and fall after SYNC_STAGES+1 edges
    add(2,  0, 1, 4'b0110, 4'b1000, 4'b0000, 4'b0000, 0);
    add(1,  0, 1, 4'b0110, 4'b1010, 4'b0010, 4'b0000, 1);
    add(2,  0, 1, 4'b0110, 4'b1010, 4'b0000, 4'b0000, 0);
    add(2,  0, 1, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 0);
    add(1,  0, 1, 4'b0100, 4'b1000, 4'b0000, 4'b0010, 1);
    add(2,  0, 1, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 0);
    // bypass raised while ch1 cnt=2: accepted on that edge, single pulse
    add(5,  0, 0, 4'b0110, 4'b1000, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b0110, 4'b1010, 4'b0010, 4'b0000, 1);
    add(2,  0, 0, 4'b0110, 4'b1010, 4'b0000, 4'b0000, 0);
    add(4,  0, 0, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 0);
    add(1,  0, 1, 4'b0100, 4'b1000, 4'b0000, 4'b0010, 1);
    add(2,  0, 0, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 0);
    // reset while ch1 cnt=2: pending change dropped, full 6 edges after release
    add(4,  0, 0, 4'b0110, 4'b1000, 4'b0000, 4'b0000, 0);
    add(1,  1, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 0);
    add(5,  0, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 0);
    add(1,  0, 0, 4'b0110, 4'b1010, 4'b1010, 4'b0000, 1);
    add(2,  0, 0, 4'b0110, 4'b1010, 4'b0000, 4'b0000, 0);

    step = 0;
    foreach (vecs[vi]) begin
      for (int r = 0; r < vecs[vi].n; r++) begin
        rst    = vecs[vi].rst;
        bypass = vecs[vi].byp;
        raw    = vecs[vi].raw;
        e.step = step;
        e.lvl  = vecs[vi].lvl;
        e.rise = vecs[vi].rise;
        e.fall = vecs[vi].fall;
        e.any  = vecs[vi].any;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        chk("level", got_e.step, level, got_e.lvl);
        chk("rise",  got_e.step, rise,  got_e.rise);
        chk("fall",  got_e.step, fall,  got_e.fall);
        chk("any_event", got_e.step, {3'b000, any_event}, {3'b000, got_e.any});
        step++;
      end
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Parametrised board-input front end between raw DE2 pins (SW, KEY) and the core's i_io_sw / i_io_btn buses.
- Handles NUM_CH channels. Each channel gets a per-channel polarity fix, a multi-flop synchroniser and a debounce filter.
- Produces clean levels plus single-cycle rise and fall pulses, so the core sees glitch-free, active-high, clock-domain-safe inputs.

Parameters:
- NUM_CH, 21, number of input channels (17 switches + 4 keys).
- SYNC_STAGES, 2, synchroniser depth; must be >= 2.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz); must be >= 1.
- ACTIVE_LOW_MASK, 21'h1E0000, bit set = channel is active-low at the pin (the KEYs).

Ports:
- i_clk  in  1  system clock (CLOCK_50).
- i_rst  in  1  synchronous reset, active-high.
- i_raw  in  NUM_CH  raw asynchronous pin levels.
- i_bypass  in  1  1 = skip debounce, behave as DEBOUNCE_CYCLES=1; quasi-static.
- o_level  out  NUM_CH  debounced, active-high level.
- o_rise  out  NUM_CH  one-cycle pulse on accepted 0->1.
- o_fall  out  NUM_CH  one-cycle pulse on accepted 1->0.
- o_any_event  out  1  one-cycle pulse, OR of all o_rise and o_fall bits.

Behaviour:
- Polarity: in = i_raw ^ ACTIVE_LOW_MASK, applied before the first sync flop. All downstream logic is active-high.
- Sync chain: SYNC_STAGES flops per channel. The last stage is s.
- Reset, held while i_rst=1 at a clock edge:
  - sync flops reset to 0.
  - o_level = 0, o_rise = 0, o_fall = 0, o_any_event = 0.
  - all counters = 0.
- Per-channel debounce counter cnt has width max(1, $clog2(DEBOUNCE_CYCLES)). Each edge:
  - if s == o_level: cnt <= 0; no pulse.
  - else if cnt == D-1, with D = (i_bypass ? 1 : DEBOUNCE_CYCLES): o_level <= s; cnt <= 0; o_rise (s=1) or o_fall (s=0) <= 1 for exactly this one cycle.
  - else: cnt <= cnt+1.
- Pulses are registered and coincide with the first cycle of the new o_level. Outside that cycle they are 0.
- Latency: from the first clock edge that samples a new, held pin value to the o_level change is SYNC_STAGES + D edges. With bypass this is SYNC_STAGES+1.
- Glitch rule: any cycle where s returns to o_level clears cnt. A pulse shorter than D synced cycles produces no output change and no pulse.
- No wrap: cnt never exceeds D-1.
- Simultaneous events: channels are fully independent. Any combination of rise and fall bits may assert in the same cycle. o_any_event is registered with them, in the same cycle.
- i_bypass toggled mid-count: the new D applies on the next edge.
  - If cnt >= new D-1 while a mismatch persists, the level is accepted on that edge.
  - Exactly one pulse per accepted change.
- Reset mid-count: pending change discarded, cnt=0. After release a full SYNC_STAGES + D edges are required.
- Elaboration: $error if SYNC_STAGES < 2, DEBOUNCE_CYCLES < 1, or NUM_CH < 1.

Decomposition:
- Package io_cond_pkg holds:
  - default constants: IO_NUM_SW=17, IO_NUM_KEY=4, IO_DEBOUNCE_10MS=500000, IO_KEY_ACTIVE_LOW_MASK.
  - a function computing counter width from DEBOUNCE_CYCLES.
- Sub-module io_debounce_ch: one channel covering the sync chain, counter, level and rise/fall pulse registers. It is instantiated NUM_CH times in a generate loop. The top adds polarity XOR and the o_any_event register.

Test Plan:
Bench config: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW_MASK=4'b1100, i_bypass=0 unless stated.
1. Reset, i_raw=4'b1100, 10 cycles with i_rst=1 then 10 with i_rst=0 -> o_level=0, o_rise=o_fall=0, o_any_event=0 throughout.
2. i_raw[0] 0->1 held, first sampled at edge E -> o_level[0]=1 after edge E+5 (6 edges). o_rise[0]=1 and o_any_event=1 for that single cycle only.
3. i_raw[1] high for 3 cycles then low -> o_level[1] stays 0; no rise[1] or fall[1] ever.
4. i_raw[2] 1->0 held (active-low key press) -> o_level[2]=1 and o_rise[2] pulse 6 edges later. Releasing to 1 -> o_fall[2] pulse 6 edges after release.
5. With ch0 at level 1: drop i_raw[0] and press i_raw[3] (1->0) on the same edge -> o_fall[0] and o_rise[3] in the same cycle; o_any_event is a single 1-cycle pulse.
6. i_bypass=1: ch1 change -> o_level[1] follows after 3 edges.
7. i_bypass=0: assert i_rst while ch1 cnt=2 -> o_level[1]=0 and no pulse; after release a full 6 edges elapse before o_level[1]=1.
